// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-side bus signals
// for the unified I/D memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic              owner;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, owner
    );

    // Pipeline + memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port unified memory: D-side priority with
// a starvation limit for I-side, fixed-latency access sequencing, ready pulses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              owner_q, owner_d;
    logic              d_wins;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            owner_q     <= owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        owner_d     = owner_q;

        // D normally wins; a starved pending fetch overrides it.
        d_wins = bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    mem_en_d = 1'b1;
                    cnt_d    = LAT_M1;
                    state_d  = ACCESS;
                    if (d_wins) begin
                        owner_d     = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        if (!bus.if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        owner_d    = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                        starve_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!mem_we_q) begin
                        if (owner_q) d_rdata_d  = bus.mem_rdata;
                        else         if_rdata_d = bus.mem_rdata;
                    end
                    if (owner_q) d_ready_d  = 1'b1;
                    else         if_ready_d = 1'b1;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.owner     = owner_q;
    assign bus.stall_if  = bus.if_req && !if_ready_q;
    assign bus.stall_mem = bus.d_req && !d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: two arbiter configurations (MEM_LAT=2/STARVE_MAX=3 and
// MEM_LAT=1/STARVE_MAX=1) checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
    logic clk;
    int   n_chk = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int cfg, input string tag,
                         input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cfg%0d %s: got 0x%08h expected 0x%08h", cfg, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int cfg, input int i);
        return 32'h8C22_0000 ^ (32'(i) * 32'h0101_0004) ^ 32'(cfg);
    endfunction

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT  = (gi == 0) ? 2 : 1;
        localparam int SMX  = (gi == 0) ? 3 : 1;
        localparam int NCYC = 3000;

        logic        rst;
        bit          done;
        logic [31:0] phys [64];

        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMX)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.mem_rdata = phys[bus.mem_addr[7:2]];

        initial begin
            logic [31:0] mdl [64];
            int          free_at, starve, g, rst_next, i_gap, d_gap, n_gnt;
            bit          have_g, g_own, g_we, dw, in_acc, rdy_i, rdy_d;
            bit          i_busy, d_busy, busy_phase;
            logic [31:0] g_wdata, g_rd, exp_addr, exp_ird, exp_drd;
            bit          exp_owner;

            done = 0;
            rst  = 1'b1;
            bus.if_req = 1'b0; bus.if_addr = '0;
            bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
            for (int i = 0; i < 64; i++) begin
                phys[i] = init_word(gi, i);
                mdl[i]  = phys[i];
            end
            @(negedge clk);
            @(negedge clk);
            check(gi, "rst_mem_en",   32'(bus.mem_en),   32'd0);
            check(gi, "rst_mem_we",   32'(bus.mem_we),   32'd0);
            check(gi, "rst_mem_addr", bus.mem_addr,      32'd0);
            check(gi, "rst_mem_wdata", bus.mem_wdata,    32'd0);
            check(gi, "rst_if_ready", 32'(bus.if_ready), 32'd0);
            check(gi, "rst_d_ready",  32'(bus.d_ready),  32'd0);
            check(gi, "rst_if_rdata", bus.if_rdata,      32'd0);
            check(gi, "rst_d_rdata",  bus.d_rdata,       32'd0);
            check(gi, "rst_owner",    32'(bus.owner),    32'd0);
            rst = 1'b0;

            free_at = 0; starve = 0; g = 0; have_g = 0; g_own = 0; g_we = 0;
            g_wdata = '0; g_rd = '0; exp_addr = '0; exp_ird = '0; exp_drd = '0;
            exp_owner = 0; i_busy = 0; d_busy = 0; i_gap = 0; d_gap = 0;
            rst_next = 700; n_gnt = 0;

            for (int e = 0; e < NCYC; e++) begin
                @(posedge clk);
                // Arbitration decision for this edge, from the stated priority rules
                if (e >= free_at && (bus.if_req || bus.d_req)) begin
                    dw = bus.d_req && !(bus.if_req && starve == SMX);
                    have_g = 1; g = e; g_own = dw; n_gnt++;
                    if (dw) begin
                        g_we     = bus.d_we;
                        exp_addr = bus.d_addr;
                        if (bus.d_we) begin
                            g_wdata = bus.d_wdata;
                            mdl[bus.d_addr[7:2]] = bus.d_wdata;
                        end else begin
                            g_rd = mdl[bus.d_addr[7:2]];
                        end
                        starve = bus.if_req ? ((starve < SMX) ? starve + 1 : starve) : 0;
                    end else begin
                        g_we     = 0;
                        exp_addr = bus.if_addr;
                        g_rd     = mdl[bus.if_addr[7:2]];
                        starve   = 0;
                    end
                    exp_owner = dw;
                    free_at   = e + LAT + 2;
                end

                @(negedge clk);
                in_acc = have_g && e >= g && e <= g + LAT - 1;
                rdy_i  = have_g && e == g + LAT && !g_own;
                rdy_d  = have_g && e == g + LAT && g_own;
                if (rdy_i) exp_ird = g_rd;
                if (rdy_d && !g_we) exp_drd = g_rd;

                check(gi, "mem_en",    32'(bus.mem_en),    32'(in_acc));
                check(gi, "mem_we",    32'(bus.mem_we),    32'(in_acc && g_we));
                check(gi, "mem_addr",  bus.mem_addr,       exp_addr);
                if (in_acc && g_we) check(gi, "mem_wdata", bus.mem_wdata, g_wdata);
                check(gi, "if_ready",  32'(bus.if_ready),  32'(rdy_i));
                check(gi, "d_ready",   32'(bus.d_ready),   32'(rdy_d));
                check(gi, "if_rdata",  bus.if_rdata,       exp_ird);
                check(gi, "d_rdata",   bus.d_rdata,        exp_drd);
                check(gi, "owner",     32'(bus.owner),     32'(exp_owner));
                check(gi, "stall_if",  32'(bus.stall_if),  32'(bus.if_req && !rdy_i));
                check(gi, "stall_mem", 32'(bus.stall_mem), 32'(bus.d_req && !rdy_d));

                if (bus.mem_en && bus.mem_we) phys[bus.mem_addr[7:2]] = bus.mem_wdata;

                busy_phase = (e < 600);
                if (rdy_i) begin
                    i_busy = 0; bus.if_req = 1'b0;
                    i_gap  = busy_phase ? 1 : $urandom_range(1, 4);
                end
                if (rdy_d) begin
                    d_busy = 0; bus.d_req = 1'b0;
                    d_gap  = busy_phase ? 1 : $urandom_range(1, 4);
                end

                // Asynchronous reset in the middle of a read access
                if (e >= rst_next && in_acc && !g_we) begin
                    rst = 1'b1;
                    #1;
                    check(gi, "arst_mem_en",   32'(bus.mem_en),   32'd0);
                    check(gi, "arst_mem_we",   32'(bus.mem_we),   32'd0);
                    check(gi, "arst_mem_addr", bus.mem_addr,      32'd0);
                    check(gi, "arst_owner",    32'(bus.owner),    32'd0);
                    check(gi, "arst_if_rdata", bus.if_rdata,      32'd0);
                    check(gi, "arst_d_rdata",  bus.d_rdata,       32'd0);
                    @(posedge clk);
                    #1;
                    check(gi, "arst_if_ready", 32'(bus.if_ready), 32'd0);
                    check(gi, "arst_d_ready",  32'(bus.d_ready),  32'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    have_g = 0; starve = 0; free_at = e + 1;
                    exp_addr = '0; exp_ird = '0; exp_drd = '0; exp_owner = 0;
                    i_busy = 0; d_busy = 0; i_gap = 0; d_gap = 0;
                    bus.if_req = 1'b0; bus.d_req = 1'b0;
                    rst_next = e + 900;
                end

                // A requester may drop req once its access is underway
                if (i_busy && in_acc && !g_own && $urandom_range(0, 7) == 0) bus.if_req = 1'b0;
                if (d_busy && in_acc && g_own && $urandom_range(0, 7) == 0) bus.d_req = 1'b0;

                if (!i_busy) begin
                    if (i_gap > 0) i_gap--;
                    else if ($urandom_range(0, 99) < (busy_phase ? 95 : 30)) begin
                        i_busy = 1; bus.if_req = 1'b1;
                        bus.if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    end
                end
                if (!d_busy) begin
                    if (d_gap > 0) d_gap--;
                    else if ($urandom_range(0, 99) < (busy_phase ? 95 : 30)) begin
                        d_busy = 1; bus.d_req = 1'b1;
                        bus.d_we    = busy_phase ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
                        bus.d_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                        bus.d_wdata = $urandom;
                    end
                end
            end
            $display("cfg%0d MEM_LAT=%0d STARVE_MAX=%0d grants=%0d", gi, LAT, SMX, n_gnt);
            done = 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wait (g_cfg[0].done && g_cfg[1].done);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
